mp_multiplier: RTL and testbench

Pipelined mixed-precision multiplier that produces the 32-bit product operand consumed by `mp_adder` on its `opb_i` port.
- Integer mode: signed 16x16 → sign-extended 32-bit product.
- FP16 mode: FP16 × FP16 → FP16, zero-extended to 32 bits, using the same special-value conventions as the adder.
- Three-stage pipeline with valid/ready handshakes on both sides; sits between the operand fetch path and the accumulate path.

---
 rtl/mp_multiplier.sv | 190 +++++++++++++++++++
 tb/tb_mp_multiplier.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_multiplier.sv
// mp_multiplier: pipelined signed int16 / FP16 multiplier whose 32-bit product feeds mp_adder opb_i.
// Optional feature: define MP_MUL_RNE_EN for FP16 round-to-nearest-even (default build truncates).
module mp_multiplier (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        data_type_i,
  input  logic [15:0] opa_i,
  input  logic [15:0] opb_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] prod_o,
  output logic        ovf_o,
  output logic        unf_o
);

  function automatic logic fp_is_inf(input logic [15:0] x);
    return (x[14:10] == 5'h1F);
  endfunction

  function automatic logic fp_is_zero(input logic [15:0] x);
    return (x[14:10] == 5'h00);
  endfunction

  logic        adv_s;
  logic        s1_valid_r, s1_fp_r, s1_inf_r, s1_zero_r;
  logic [15:0] s1_a_r, s1_b_r;
  logic        s2_valid_r, s2_fp_r, s2_sign_r, s2_inf_r, s2_zero_r;
  logic [31:0] s2_int_r;
  logic [21:0] s2_mant_r;
  logic [6:0]  s2_exp_r;
  logic        s3_valid_r, s3_fp_r, s3_sign_r, s3_inf_r, s3_zero_r;
  logic [31:0] s3_int_r;
  logic [6:0]  s3_exp_r;
  logic [9:0]  s3_frac_r;
  logic [31:0] int_prod_s;
  logic [21:0] mant_prod_s;
  logic [6:0]  exp_sum_s;
  logic [6:0]  norm_exp_s;
  logic [9:0]  norm_frac_s;
  logic        guard_s, sticky_s;
  logic [31:0] pack_prod_s;
  logic        pack_ovf_s, pack_unf_s;

  // A stalled output freezes every stage, so one enable serves the whole pipe.
  assign adv_s   = !valid_o || ready_i;
  assign ready_o = adv_s;

  // S1: capture operands and classify FP16 specials (NaN folds into INF).
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid_r <= 1'b0;
      s1_fp_r    <= 1'b0;
      s1_inf_r   <= 1'b0;
      s1_zero_r  <= 1'b0;
      s1_a_r     <= 16'h0000;
      s1_b_r     <= 16'h0000;
    end else if (adv_s) begin
      s1_valid_r <= valid_i;
      s1_fp_r    <= data_type_i;
      s1_inf_r   <= fp_is_inf(opa_i) || fp_is_inf(opb_i);
      s1_zero_r  <= fp_is_zero(opa_i) || fp_is_zero(opb_i);
      s1_a_r     <= opa_i;
      s1_b_r     <= opb_i;
    end
  end

  // S2 datapath: integer product, 11x11 mantissa product and rebiased exponent.
  always_comb begin
    int_prod_s  = {{16{s1_a_r[15]}}, s1_a_r} * {{16{s1_b_r[15]}}, s1_b_r};
    mant_prod_s = {11'd0, 1'b1, s1_a_r[9:0]} * {11'd0, 1'b1, s1_b_r[9:0]};
    exp_sum_s   = {2'b00, s1_a_r[14:10]} + {2'b00, s1_b_r[14:10]} - 7'd15;
  end

  // S2 register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s2_valid_r <= 1'b0;
      s2_fp_r    <= 1'b0;
      s2_sign_r  <= 1'b0;
      s2_inf_r   <= 1'b0;
      s2_zero_r  <= 1'b0;
      s2_int_r   <= 32'h0000_0000;
      s2_mant_r  <= 22'd0;
      s2_exp_r   <= 7'd0;
    end else if (adv_s) begin
      s2_valid_r <= s1_valid_r;
      s2_fp_r    <= s1_fp_r;
      s2_sign_r  <= s1_a_r[15] ^ s1_b_r[15];
      s2_inf_r   <= s1_inf_r;
      s2_zero_r  <= s1_zero_r;
      s2_int_r   <= int_prod_s;
      s2_mant_r  <= mant_prod_s;
      s2_exp_r   <= exp_sum_s;
    end
  end

  // S3 normalize: mantissa product lies in [1,4), so at most one right shift.
  always_comb begin
    if (s2_mant_r[21]) begin
      norm_exp_s  = s2_exp_r + 7'd1;
      norm_frac_s = s2_mant_r[20:11];
      guard_s     = s2_mant_r[10];
      sticky_s    = |s2_mant_r[9:0];
    end else begin
      norm_exp_s  = s2_exp_r;
      norm_frac_s = s2_mant_r[19:10];
      guard_s     = s2_mant_r[9];
      sticky_s    = |s2_mant_r[8:0];
    end
`ifdef MP_MUL_RNE_EN
    // Round-half-even; a carry out of the fraction leaves it zero and bumps exp.
    if (guard_s && (sticky_s || norm_frac_s[0])) begin
      if (norm_frac_s == 10'h3FF) begin
        norm_exp_s = norm_exp_s + 7'd1;
      end else begin
        norm_exp_s = norm_exp_s;
      end
      norm_frac_s = norm_frac_s + 10'd1;
    end else begin
      norm_frac_s = norm_frac_s;
    end
`endif
  end

  // S3 register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s3_valid_r <= 1'b0;
      s3_fp_r    <= 1'b0;
      s3_sign_r  <= 1'b0;
      s3_inf_r   <= 1'b0;
      s3_zero_r  <= 1'b0;
      s3_int_r   <= 32'h0000_0000;
      s3_exp_r   <= 7'd0;
      s3_frac_r  <= 10'd0;
    end else if (adv_s) begin
      s3_valid_r <= s2_valid_r;
      s3_fp_r    <= s2_fp_r;
      s3_sign_r  <= s2_sign_r;
      s3_inf_r   <= s2_inf_r;
      s3_zero_r  <= s2_zero_r;
      s3_int_r   <= s2_int_r;
      s3_exp_r   <= norm_exp_s;
      s3_frac_r  <= norm_frac_s;
    end
  end

  // Pack: INF operand beats zero operand, which beats exponent range checks.
  always_comb begin
    pack_prod_s = s3_int_r;
    pack_ovf_s  = 1'b0;
    pack_unf_s  = 1'b0;
    if (s3_fp_r) begin
      if (s3_inf_r) begin
        pack_prod_s = {16'h0000, s3_sign_r, 5'h1F, 10'h000};
        pack_ovf_s  = 1'b1;
      end else if (s3_zero_r) begin
        pack_prod_s = 32'h0000_0000;
      end else if ($signed(s3_exp_r) >= 7'sd31) begin
        pack_prod_s = {16'h0000, s3_sign_r, 5'h1F, 10'h000};
        pack_ovf_s  = 1'b1;
      end else if ($signed(s3_exp_r) <= 7'sd0) begin
        pack_prod_s = 32'h0000_0000;
        pack_unf_s  = 1'b1;
      end else begin
        pack_prod_s = {16'h0000, s3_sign_r, s3_exp_r[4:0], s3_frac_r};
      end
    end else begin
      pack_prod_s = s3_int_r;
    end
  end

  // Output register: holds while the downstream stalls.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_o <= 1'b0;
      prod_o  <= 32'h0000_0000;
      ovf_o   <= 1'b0;
      unf_o   <= 1'b0;
    end else if (adv_s) begin
      valid_o <= s3_valid_r;
      prod_o  <= pack_prod_s;
      ovf_o   <= pack_ovf_s;
      unf_o   <= pack_unf_s;
    end
  end

endmodule

// File: tb/tb_mp_multiplier.sv
// tb_mp_multiplier: directed vector table, backpressure, reset and randomized
// streams against a real-arithmetic reference model of mp_multiplier.
module tb_mp_multiplier;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        data_type_i = 1'b0;
  logic [15:0] opa_i = 16'h0000;
  logic [15:0] opb_i = 16'h0000;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [31:0] prod_o;
  logic        ovf_o;
  logic        unf_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        fp;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] prod;
    logic        ovf;
    logic        unf;
  } vec_t;

  mp_multiplier dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_type_i(data_type_i),
    .opa_i      (opa_i),
    .opb_i      (opb_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .prod_o     (prod_o),
    .ovf_o      (ovf_o),
    .unf_o      (unf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference: operate on the real values, then normalize and round numerically.
  function automatic vec_t ref_mul(input logic fp, input logic [15:0] a, input logic [15:0] b);
    vec_t r;
    int ea, eb, e, m;
    real v, f, rem;
    logic sign;
    r.fp = fp; r.a = a; r.b = b; r.ovf = 1'b0; r.unf = 1'b0;
    if (!fp) begin
      r.prod = 32'(int'($signed(a)) * int'($signed(b)));
      return r;
    end
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    sign = a[15] ^ b[15];
    if (ea == 31 || eb == 31) begin
      r.prod = {16'h0000, sign, 5'h1F, 10'h000};
      r.ovf  = 1'b1;
      return r;
    end
    if (ea == 0 || eb == 0) begin
      r.prod = 32'h0000_0000;
      return r;
    end
    v = (1.0 + real'(a[9:0]) / 1024.0) * (1.0 + real'(b[9:0]) / 1024.0);
    e = ea + eb - 15;
    if (v >= 2.0) begin
      v = v / 2.0;
      e = e + 1;
    end
    f = (v - 1.0) * 1024.0;
    m = $rtoi(f);
`ifdef MP_MUL_RNE_EN
    rem = f - real'(m);
    if (rem > 0.5 || (rem == 0.5 && (m % 2) == 1)) m = m + 1;
    if (m == 1024) begin
      m = 0;
      e = e + 1;
    end
`else
    rem = 0.0;
`endif
    if (e >= 31) begin
      r.prod = {16'h0000, sign, 5'h1F, 10'h000};
      r.ovf  = 1'b1;
    end else if (e <= 0) begin
      r.prod = 32'h0000_0000;
      r.unf  = 1'b1;
    end else begin
      r.prod = {16'h0000, sign, e[4:0], m[9:0]};
    end
    return r;
  endfunction

  function automatic logic [15:0] rand_op(input logic fp);
    logic [15:0] x;
    x = 16'($urandom);
    if (fp && $urandom_range(0, 3) != 0) x[14:10] = 5'($urandom_range(8, 22));
    return x;
  endfunction

  // One beat into an empty pipe: measure edges from acceptance to valid_o.
  task automatic send_single(input string tag, input vec_t v);
    int k;
    valid_i = 1'b1; data_type_i = v.fp; opa_i = v.a; opb_i = v.b; ready_i = 1'b1;
    @(negedge clk_i);
    check({tag, " accept"}, 64'(ready_o), 64'(1'b1));
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    k = 0;
    @(negedge clk_i);
    while (!valid_o && k < 20) begin
      @(posedge clk_i);
      k++;
      @(negedge clk_i);
    end
    check({tag, " latency"}, 64'(k), 64'(3));
    check({tag, " value"}, 64'({ovf_o, unf_o, prod_o}), 64'({v.ovf, v.unf, v.prod}));
    @(posedge clk_i); #1;
  endtask

  // Streams beats through the DUT with a scoreboard; ready_i from a window or random.
  task automatic run_stream(input string tag, input vec_t beats[$], input int stall_start,
                            input int stall_len, input bit rand_ready, output int low_cycles);
    vec_t exp_q[$];
    vec_t e;
    int idx, got, cyc;
    logic held;
    logic [33:0] hold_val;
    idx = 0; got = 0; cyc = 0; held = 1'b0; hold_val = 34'd0; low_cycles = 0;
    while (got < beats.size() && cyc < 4000) begin
      if (idx < beats.size()) begin
        valid_i = 1'b1; data_type_i = beats[idx].fp; opa_i = beats[idx].a; opb_i = beats[idx].b;
      end else begin
        valid_i = 1'b0;
      end
      if (rand_ready) ready_i = ($urandom_range(0, 3) != 0);
      else ready_i = !(cyc >= stall_start && cyc < stall_start + stall_len);
      @(negedge clk_i);
      check({tag, " ready_o"}, 64'(ready_o), 64'(!valid_o || ready_i));
      if (held) check({tag, " hold"}, 64'({valid_o, ovf_o, unf_o, prod_o}), 64'({1'b1, hold_val}));
      if (!ready_o) low_cycles++;
      if (valid_i && ready_o) begin
        exp_q.push_back(beats[idx]);
        idx++;
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL %s extra beat: got %h, expected none", tag, prod_o);
        end else begin
          e = exp_q.pop_front();
          check({tag, " beat"}, 64'({ovf_o, unf_o, prod_o}), 64'({e.ovf, e.unf, e.prod}));
        end
        got++;
      end
      held = valid_o && !ready_i;
      hold_val = {ovf_o, unf_o, prod_o};
      @(posedge clk_i); #1;
      cyc++;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    if (got < beats.size()) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout: got %0d beats, expected %0d", tag, got, beats.size());
    end
  endtask

  initial begin
    vec_t tbl[12];
    vec_t q[$];
    int lc, stale;

    tbl[0]  = '{1'b0, 16'hFFFD, 16'h0007, 32'hFFFF_FFEB, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 16'h8000, 16'h8000, 32'h4000_0000, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 16'h3E00, 16'h4000, 32'h0000_4200, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 16'h7BFF, 16'h4000, 32'h0000_7C00, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 16'h0400, 16'h0400, 32'h0000_0000, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 16'hFC00, 16'h3C00, 32'h0000_FC00, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 16'h7E00, 16'h0000, 32'h0000_7C00, 1'b1, 1'b0};
`ifdef MP_MUL_RNE_EN
    tbl[7]  = '{1'b1, 16'h3E01, 16'h3E01, 32'h0000_4082, 1'b0, 1'b0};
`else
    tbl[7]  = '{1'b1, 16'h3E01, 16'h3E01, 32'h0000_4081, 1'b0, 1'b0};
`endif
    tbl[8]  = '{1'b0, 16'h7FFF, 16'h7FFF, 32'h3FFF_0001, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 16'h0000, 16'h7C00, 32'h0000_7C00, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 16'h8000, 16'h3C00, 32'h0000_0000, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 16'hC000, 16'h3C00, 32'h0000_C000, 1'b0, 1'b0};

    // Reset state.
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("reset valid_o", 64'(valid_o), 64'(1'b0));
    check("reset outputs", 64'({ovf_o, unf_o, prod_o}), 64'(0));
    check("reset ready_o", 64'(ready_o), 64'(1'b1));
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;

    // Directed vectors one at a time, then back-to-back with mixed modes.
    for (int i = 0; i < 12; i++) send_single($sformatf("vec%0d", i), tbl[i]);
    q.delete();
    for (int i = 0; i < 12; i++) q.push_back(tbl[i]);
    run_stream("b2b", q, 0, 0, 1'b0, lc);

    // Backpressure: ready_i low for 5 cycles starting at beat 2.
    q.delete();
    q.push_back(tbl[0]); q.push_back(tbl[2]); q.push_back(tbl[1]);
    q.push_back(tbl[3]); q.push_back(tbl[8]); q.push_back(tbl[7]);
    run_stream("bp", q, 2, 5, 1'b0, lc);
    check("bp ready_o dropped", 64'(lc > 0), 64'(1'b1));

    // Randomized mixed-mode traffic with random backpressure.
    q.delete();
    for (int i = 0; i < 300; i++) begin
      logic fp;
      fp = 1'($urandom_range(0, 1));
      q.push_back(ref_mul(fp, rand_op(fp), rand_op(fp)));
    end
    run_stream("rand", q, 0, 0, 1'b1, lc);

    // Reset with a stalled output and three beats behind it.
    ready_i = 1'b0; valid_i = 1'b1; data_type_i = 1'b0; opa_i = 16'hFFFD; opb_i = 16'h0007;
    repeat (6) @(posedge clk_i);
    #1;
    check("rst pre valid_o", 64'(valid_o), 64'(1'b1));
    check("rst pre prod_o", 64'(prod_o), 64'(32'hFFFF_FFEB));
    #2 rst_n_i = 1'b0;
    #1;
    check("rst valid_o", 64'(valid_o), 64'(1'b0));
    check("rst prod_o", 64'({ovf_o, unf_o, prod_o}), 64'(0));
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    rst_n_i = 1'b1;
    #1;
    check("rst ready_o", 64'(ready_o), 64'(1'b1));
    send_single("post-rst", tbl[2]);
    stale = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (valid_o) stale++;
    end
    check("rst no stale beats", 64'(stale), 64'(0));
    @(posedge clk_i); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
